// File: rtl/vmc_pkg.sv
// vmc_pkg: shared types and default sizing for the vector memory controller.
//   op_t      - access pattern of a request (scalar broadcast, horizontal, vertical)
//   state_t   - controller FSM states
//   VMC_*     - default parameter values used by the controller and address generator
//   lane_idx_w - width needed to index LANES lanes (at least 1 bit)
package vmc_pkg;

    localparam int unsigned VMC_ADDR_W = 32;
    localparam int unsigned VMC_MEM_W  = 16;
    localparam int unsigned VMC_LANES  = 3;

    // OP encoding 2'b11 is reserved; requests carrying it are dropped in IDLE.
    localparam logic [1:0] OP_RESERVED = 2'b11;

    typedef enum logic [1:0] {
        SCALAR = 2'b00,
        HORIZ  = 2'b01,
        VERT   = 2'b10
    } op_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_t;

    function automatic int unsigned lane_idx_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vmc_addr_gen.sv
// vmc_addr_gen: combinational lane address generator.
//   base_i - base address {row, col}; row is the upper half, col the lower half
//   op_i   - access pattern
//   lane_i - lane index being issued
//   addr_o - memory address for that lane
// Row and column are stepped independently and wrap inside their own field.
module vmc_addr_gen
    import vmc_pkg::*;
#(
    parameter int unsigned ADDR_W = VMC_ADDR_W,
    parameter int unsigned LW     = 2
) (
    input  logic [ADDR_W-1:0] base_i,
    input  op_t               op_i,
    input  logic [LW-1:0]     lane_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int unsigned HW = ADDR_W / 2;

    logic [HW-1:0] row;
    logic [HW-1:0] col;
    logic [HW-1:0] step;

    always_comb begin
        row    = base_i[ADDR_W-1:HW];
        col    = base_i[HW-1:0];
        step   = HW'(lane_i);
        addr_o = base_i;
        case (op_i)
            HORIZ:   addr_o = {row, HW'(col + step)};
            VERT:    addr_o = {HW'(row + step), col};
            default: addr_o = base_i;
        endcase
    end

endmodule

// File: rtl/vector_mem_controller.sv
// vector_mem_controller: moves LANES-word vectors between a request port and a
// synchronous single-port word memory.
//   CLK, RESET_N        - clock and asynchronous active-low reset
//   START/OP/WRITE      - request strobe, access pattern, direction (sampled in IDLE only)
//   ADDRESS, WDATA      - base {row, col} and write vector (lane i at [i*MEM_W +: MEM_W])
//   MEM_ADDR/WE/WDATA   - memory request, one lane per ISSUE cycle
//   MEM_RDATA           - memory read data, valid the cycle after MEM_ADDR
//   RDATA               - assembled read vector, held until the next read overwrites it
//   BUSY, DONE          - busy outside IDLE; DONE is a one-cycle completion pulse
module vector_mem_controller
    import vmc_pkg::*;
#(
    parameter int unsigned  ADDR_W = VMC_ADDR_W,
    parameter int unsigned  MEM_W  = VMC_MEM_W,
    parameter int unsigned  LANES  = VMC_LANES,
    localparam int unsigned VW     = MEM_W * LANES
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [1:0]        OP,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [VW-1:0]     WDATA,
    input  logic [MEM_W-1:0]  MEM_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_WE,
    output logic [MEM_W-1:0]  MEM_WDATA,
    output logic [VW-1:0]     RDATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned     LW        = lane_idx_w(LANES);
    localparam logic [LW-1:0]   LAST_LANE = LW'(LANES - 1);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [VW-1:0]     wdata_q, wdata_d;
    logic [VW-1:0]     rdata_q, rdata_d;
    logic [LW-1:0]     lane_q, lane_d;
    // Read capture is one cycle behind issue: cap_q marks that MEM_RDATA this
    // cycle belongs to lane cap_lane_q.
    logic              cap_q, cap_d;
    logic [LW-1:0]     cap_lane_q, cap_lane_d;

    logic [LW-1:0]     last_lane;
    logic [ADDR_W-1:0] lane_addr;

    vmc_addr_gen #(
        .ADDR_W (ADDR_W),
        .LW     (LW)
    ) u_addr_gen (
        .base_i (base_q),
        .op_i   (op_q),
        .lane_i (lane_q),
        .addr_o (lane_addr)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        write_d    = write_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        lane_d     = lane_q;
        cap_d      = 1'b0;
        cap_lane_d = cap_lane_q;
        last_lane  = (op_q == SCALAR) ? '0 : LAST_LANE;

        unique case (state_q)
            StIdle: begin
                if (START && (OP != OP_RESERVED)) begin
                    op_d    = op_t'(OP);
                    write_d = WRITE;
                    base_d  = ADDRESS;
                    wdata_d = WDATA;
                    lane_d  = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cap_d      = ~write_q;
                cap_lane_d = lane_q;
                if (lane_q == last_lane) begin
                    lane_d  = '0;
                    // Writes have nothing in flight; reads need one more cycle
                    // to capture the last lane.
                    state_d = write_q ? StDone : StWait;
                end else begin
                    lane_d = lane_q + LW'(1);
                end
            end
            StWait: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (cap_q) begin
            if (op_q == SCALAR) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    rdata_d[i*MEM_W +: MEM_W] = MEM_RDATA;
                end
            end else begin
                rdata_d[MEM_W * 32'(cap_lane_q) +: MEM_W] = MEM_RDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            op_q       <= SCALAR;
            write_q    <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            lane_q     <= '0;
            cap_q      <= 1'b0;
            cap_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            write_q    <= write_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            lane_q     <= lane_d;
            cap_q      <= cap_d;
            cap_lane_q <= cap_lane_d;
        end
    end

    // Memory-side outputs decode straight from state so reset clears them at once.
    always_comb begin
        MEM_ADDR  = '0;
        MEM_WE    = 1'b0;
        MEM_WDATA = '0;
        if (state_q == StIssue) begin
            MEM_ADDR = lane_addr;
            MEM_WE   = write_q;
            if (write_q) begin
                MEM_WDATA = wdata_q[MEM_W * 32'(lane_q) +: MEM_W];
            end
        end
    end

    assign RDATA = rdata_q;
    assign BUSY  = (state_q != StIdle);
    assign DONE  = (state_q == StDone);

endmodule

// File: tb/tb_vector_mem_controller.sv
// Bench for vector_mem_controller: directed cases with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_vector_mem_controller;

    localparam int unsigned AW = 32;
    localparam int unsigned MW = 16;
    localparam int unsigned LN = 3;
    localparam int unsigned VW = MW * LN;

    logic          CLK     = 1'b0;
    logic          RESET_N = 1'b0;
    logic          START   = 1'b0;
    logic [1:0]    OP      = 2'b00;
    logic          WRITE   = 1'b0;
    logic [AW-1:0] ADDRESS = '0;
    logic [VW-1:0] WDATA   = '0;
    logic [MW-1:0] MEM_RDATA = '0;
    logic [AW-1:0] MEM_ADDR;
    logic          MEM_WE;
    logic [MW-1:0] MEM_WDATA;
    logic [VW-1:0] RDATA;
    logic          BUSY;
    logic          DONE;

    vector_mem_controller #(
        .ADDR_W (AW),
        .MEM_W  (MW),
        .LANES  (LN)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .OP        (OP),
        .WRITE     (WRITE),
        .ADDRESS   (ADDRESS),
        .WDATA     (WDATA),
        .MEM_RDATA (MEM_RDATA),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WE    (MEM_WE),
        .MEM_WDATA (MEM_WDATA),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    function automatic logic [15:0] preload(input logic [31:0] a);
        return {a[23:16], a[7:0]};
    endfunction

    // Environment RAM: synchronous read, write-enabled, preloaded pattern.
    logic [15:0] env_ram [logic [31:0]];
    always @(posedge CLK) begin
        if (env_ram.exists(MEM_ADDR)) MEM_RDATA <= env_ram[MEM_ADDR];
        else MEM_RDATA <= preload(MEM_ADDR);
        if (MEM_WE) env_ram[MEM_ADDR] = MEM_WDATA;
    end

    // ---------------- transaction-level reference model ----------------
    logic [15:0] m_mem [logic [31:0]];
    logic        m_busy = 1'b0;
    logic        m_wr;
    logic        m_scalar;
    int          m_k, m_n, m_lat;
    logic [31:0] m_addr [LN];
    logic [15:0] m_wd   [LN];
    logic [15:0] m_rd   [LN];
    logic [VW-1:0] e_rdata = '0;

    function automatic logic [15:0] model_read(input logic [31:0] a);
        return m_mem.exists(a) ? m_mem[a] : preload(a);
    endfunction

    task automatic model_accept();
        logic [15:0] row, col, step;
        row      = ADDRESS[31:16];
        col      = ADDRESS[15:0];
        m_scalar = (OP == 2'b00);
        m_wr     = WRITE;
        m_n      = m_scalar ? 1 : LN;
        m_lat    = m_wr ? m_n + 1 : m_n + 2;
        for (int i = 0; i < LN; i++) begin
            step = 16'(i);
            if (OP == 2'b01)      m_addr[i] = {row, 16'(col + step)};
            else if (OP == 2'b10) m_addr[i] = {16'(row + step), col};
            else                  m_addr[i] = ADDRESS;
            m_wd[i] = WDATA[i*MW +: MW];
            m_rd[i] = model_read(m_addr[i]);
        end
        m_busy = 1'b1;
        m_k    = 1;
    endtask

    int cyc = 0;
    always @(negedge CLK) begin
        cyc++;
        if (!RESET_N) begin
            chk("rst_busy",  64'(BUSY), 64'(0));
            chk("rst_done",  64'(DONE), 64'(0));
            chk("rst_we",    64'(MEM_WE), 64'(0));
            chk("rst_addr",  64'(MEM_ADDR), 64'(0));
            chk("rst_wdata", 64'(MEM_WDATA), 64'(0));
            chk("rst_rdata", 64'(RDATA), 64'(0));
            m_busy  = 1'b0;
            e_rdata = '0;
        end else begin
            chk("busy",  64'(BUSY), 64'(m_busy));
            chk("done",  64'(DONE), 64'(m_busy && m_k == m_lat));
            chk("we",    64'(MEM_WE), 64'(m_busy && m_wr && m_k <= m_n));
            if (m_busy && m_k <= m_n) begin
                chk("mem_addr", 64'(MEM_ADDR), 64'(m_addr[m_k-1]));
                if (m_wr) begin
                    chk("mem_wdata", 64'(MEM_WDATA), 64'(m_wd[m_k-1]));
                    m_mem[m_addr[m_k-1]] = m_wd[m_k-1];
                end
            end
            chk("rdata", 64'(RDATA), 64'(e_rdata));
            // Advance to the cycle after the coming edge.
            if (m_busy) begin
                if (m_k == m_lat) m_busy = 1'b0;
                else m_k++;
            end else if (START && OP != 2'b11) begin
                model_accept();
            end
            // Lane i of a read becomes visible three cycles after acceptance plus i.
            if (m_busy && !m_wr) begin
                if (m_scalar) begin
                    if (m_k == 3) for (int i = 0; i < LN; i++) e_rdata[i*MW +: MW] = m_rd[0];
                end else if (m_k >= 3 && m_k < 3 + LN) begin
                    e_rdata[(m_k-3)*MW +: MW] = m_rd[m_k-3];
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [31:0] seen_addr [8];
    logic [15:0] seen_wd   [8];
    int          seen_we;
    int          seen_done;
    int          got_lat;
    logic [VW-1:0] got_rd;

    task automatic wait_done();
        got_lat = -1;
        seen_we = 0;
        got_rd  = '0;
        for (int k = 1; k <= 20 && got_lat < 0; k++) begin
            @(negedge CLK);
            if (k < 8) begin
                seen_addr[k] = MEM_ADDR;
                seen_wd[k]   = MEM_WDATA;
            end
            if (MEM_WE) seen_we++;
            if (DONE) begin
                got_lat = k;
                got_rd  = RDATA;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic wr, input logic [31:0] a,
                          input logic [VW-1:0] wd);
        @(posedge CLK); #1;
        START = 1'b1; OP = op; WRITE = wr; ADDRESS = a; WDATA = wd;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done();
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'h0001;
            2: return 16'h0002;
            3: return 16'h0003;
            4: return 16'hFFFE;
            default: return 16'hFFFF;
        endcase
    endfunction

    initial begin
        logic [63:0] wd64;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_busy", 64'(BUSY), 64'(0));
        chk("reset_rdata", 64'(RDATA), 64'(0));
        RESET_N = 1'b1;

        run_op(2'b00, 1'b0, 32'h0001_0002, '0);
        chk("scalar_rd_lat", 64'(got_lat), 64'(3));
        chk("scalar_rd_data", 64'(got_rd), 64'h0102_0102_0102);

        run_op(2'b10, 1'b0, 32'h0002_0001, '0);
        chk("vert_rd_lat", 64'(got_lat), 64'(5));
        chk("vert_addr0", 64'(seen_addr[1]), 64'h0002_0001);
        chk("vert_addr1", 64'(seen_addr[2]), 64'h0003_0001);
        chk("vert_addr2", 64'(seen_addr[3]), 64'h0004_0001);
        chk("vert_rd_data", 64'(got_rd), 64'h0401_0301_0201);

        run_op(2'b01, 1'b0, 32'h0005_FFFF, '0);
        chk("horiz_addr0", 64'(seen_addr[1]), 64'h0005_FFFF);
        chk("horiz_addr1", 64'(seen_addr[2]), 64'h0005_0000);
        chk("horiz_addr2", 64'(seen_addr[3]), 64'h0005_0001);
        chk("horiz_rd_data", 64'(got_rd), 64'h0501_0500_05FF);

        run_op(2'b10, 1'b1, 32'h0001_0000, 48'hCCCC_BBBB_AAAA);
        chk("vert_wr_lat", 64'(got_lat), 64'(4));
        chk("vert_wr_we_cycles", 64'(seen_we), 64'(3));
        chk("vert_wr_d0", 64'(seen_wd[1]), 64'hAAAA);
        chk("vert_wr_d1", 64'(seen_wd[2]), 64'hBBBB);
        chk("vert_wr_d2", 64'(seen_wd[3]), 64'hCCCC);
        run_op(2'b10, 1'b0, 32'h0001_0000, '0);
        chk("vert_readback", 64'(got_rd), 64'hCCCC_BBBB_AAAA);

        run_op(2'b00, 1'b1, 32'h0007_0007, 48'h1111_2222_3333);
        chk("scalar_wr_lat", 64'(got_lat), 64'(2));
        chk("scalar_wr_we_cycles", 64'(seen_we), 64'(1));
        chk("scalar_wr_d0", 64'(seen_wd[1]), 64'h3333);
        run_op(2'b01, 1'b0, 32'h0007_0006, '0);
        chk("horiz_after_scalar_wr", 64'(got_rd), 64'h0708_3333_0706);

        // Reserved OP must not start anything.
        @(posedge CLK); #1;
        START = 1'b1; OP = 2'b11; WRITE = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (BUSY) seen_done++;
        end
        chk("reserved_op_busy_cycles", 64'(seen_done), 64'(0));
        @(posedge CLK); #1;
        START = 1'b0;

        // START pulsed mid-operation is dropped: exactly one DONE.
        @(posedge CLK); #1;
        START = 1'b1; OP = 2'b10; WRITE = 1'b0; ADDRESS = 32'h0002_0001;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #1;
        START = 1'b1; OP = 2'b00;
        @(posedge CLK); #1;
        START = 1'b0;
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (DONE) seen_done++;
        end
        chk("busy_start_done_count", 64'(seen_done), 64'(1));

        // Reset in the middle of a vector read.
        @(posedge CLK); #1;
        START = 1'b1; OP = 2'b01; WRITE = 1'b0; ADDRESS = 32'h0005_FFFF;
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #2;
        chk("pre_reset_busy", 64'(BUSY), 64'(1));
        RESET_N = 1'b0;
        #1;
        chk("midrst_busy", 64'(BUSY), 64'(0));
        chk("midrst_we", 64'(MEM_WE), 64'(0));
        chk("midrst_addr", 64'(MEM_ADDR), 64'(0));
        chk("midrst_rdata", 64'(RDATA), 64'(0));
        seen_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            if (DONE) seen_done++;
        end
        chk("midrst_no_done", 64'(seen_done), 64'(0));
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        START = 1'b1; OP = 2'b00; WRITE = 1'b0; ADDRESS = 32'h0001_0002;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done();
        chk("post_reset_lat", 64'(got_lat), 64'(3));
        chk("post_reset_data", 64'(got_rd), 64'h0102_0102_0102);

        // Randomized traffic, including one reset burst.
        for (int c = 0; c < 600; c++) begin
            @(posedge CLK); #1;
            if (c == 300) RESET_N = 1'b0;
            if (c == 303) RESET_N = 1'b1;
            START   = ($urandom_range(0, 2) == 0);
            OP      = 2'($urandom_range(0, 3));
            WRITE   = 1'($urandom_range(0, 1));
            ADDRESS = {pick16(), pick16()};
            wd64    = {$urandom, $urandom};
            WDATA   = wd64[VW-1:0];
        end
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vector_mem_controller.md
VECTOR_MEM_CONTROLLER -- requirements
Module: vector_mem_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: ADDRESS width, split into row (upper ADDR_W/2 bits) and column (lower ADDR_W/2 bits).
REQ-002 SHALL have parameter MEM_W, default 16: memory word width.
REQ-003 SHALL have parameter LANES, default 3: words per vector; vector width VW = MEM_W*LANES.
REQ-004 SHALL have one clock, CLK, and reset RESET_N, asynchronous and active-low.
REQ-005 CLK  in  1: single clock for all logic.
REQ-006 RESET_N  in  1: asynchronous active-low reset.
REQ-007 START  in  1: request; sampled only in IDLE.
REQ-008 OP  in  2: 00 scalar-broadcast, 01 horizontal, 10 vertical, 11 reserved (ignored).
REQ-009 WRITE  in  1: 1 = write, 0 = read.
REQ-010 ADDRESS  in  ADDR_W: base {row, col}.
REQ-011 WDATA  in  VW: write vector, lane i = bits [i*MEM_W +: MEM_W].
REQ-012 MEM_RDATA  in  MEM_W: synchronous memory read data, valid one cycle after MEM_ADDR.
REQ-013 MEM_ADDR  out  ADDR_W; MEM_WE  out  1; MEM_WDATA  out  MEM_W.
REQ-014 RDATA  out  VW; BUSY  out  1; DONE  out  1 (single-cycle pulse).

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: START=1 with OP!=11 SHALL latch OP, WRITE, ADDRESS and WDATA, then go to ISSUE; BUSY=1 in every non-IDLE state.
REQ-017 ISSUE SHALL last N cycles (N=1 for scalar, N=LANES otherwise), driving the lane-i address in the i-th cycle.
REQ-018 Horizontal lane i address SHALL be {row, (col+i) mod 2^(ADDR_W/2)}; vertical SHALL be {(row+i) mod 2^(ADDR_W/2), col}; scalar SHALL be base only. No carry crosses fields.
REQ-019 Read: MEM_RDATA SHALL be captured into lane i one cycle after lane i is issued; after the last ISSUE cycle, go to WAIT (last capture), then DONE.
REQ-020 Scalar read SHALL broadcast the single word to all LANES lanes of RDATA.
REQ-021 Write: MEM_WE=1 and MEM_WDATA=lane i during each ISSUE cycle; scalar writes lane 0 only; skip WAIT, go directly to DONE.
REQ-022 Latency from START cycle t: vector read DONE at t+LANES+2, scalar read t+3, vector write t+LANES+1, scalar write t+2.
REQ-023 DONE SHALL be high exactly one cycle, then return to IDLE; RDATA SHALL hold until the next read's first capture.
REQ-024 START outside IDLE SHALL be ignored (no queueing); OP=11 in IDLE SHALL be ignored.
REQ-025 MEM_WE SHALL be 0 in all states except write ISSUE cycles.

Reset
REQ-026 RESET_N low SHALL force IDLE immediately and clear RDATA, MEM_ADDR, MEM_WDATA, MEM_WE, BUSY and DONE to 0, including mid-operation.
REQ-027 After release, the first START SHALL be accepted on the first rising edge with RESET_N high.

Structure
REQ-028 Package vmc_pkg SHALL hold the op_t enum (SCALAR, HORIZ, VERT), the state_t enum and the default parameter constants.
REQ-029 Lane address computation SHALL be a sub-module vmc_addr_gen (base, op, lane index -> address, combinational).

Verification (bench RAM model: sync, writable, preload mem[{r,c}] = {r[7:0], c[7:0]}; defaults)
REQ-030 Scalar read at 32'h00010002 -> RDATA=48'h0102_0102_0102, DONE at t+3.
REQ-031 Vertical read at 32'h00020001 -> MEM_ADDR 00020001, 00030001, 00040001; RDATA=48'h0401_0301_0201; DONE at t+5.
REQ-032 Horizontal read at 32'h0005FFFF -> column wraps: 0005FFFF, 00050000, 00050001; RDATA=48'h0501_0500_05FF.
REQ-033 Vertical write WDATA=48'hCCCC_BBBB_AAAA at 32'h00010000 -> MEM_WE high 3 cycles, data AAAA/BBBB/CCCC, DONE at t+4; then vertical read at the same address -> 48'hCCCC_BBBB_AAAA.
REQ-034 START pulsed during BUSY -> ignored, single DONE; RESET_N low during vector ISSUE -> all outputs 0 next cycle, no DONE; next request completes normally.
